// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Resolves memory wait, taken-branch redirect, mult/div occupancy and
// load-use hazards into per-register hold (stall) and bubble (clear) controls.
// Also keeps a memory-wait watchdog and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY  = 32,
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           D_rs,
    input  logic [4:0]           D_rt,
    input  logic                 D_hilo_rd,
    input  logic [4:0]           E_rd,
    input  logic                 E_w_reg_ena,
    input  logic                 E_mem_read,
    input  logic                 E_md_start,
    input  logic                 E_branch_taken,
    input  logic                 M_mem_req,
    input  logic                 M_mem_ack,
    output logic                 F_stall,
    output logic                 D_stall,
    output logic                 E_stall,
    output logic                 M_stall,
    output logic                 W_stall,
    output logic                 D_clear,
    output logic                 E_clear,
    output logic                 M_clear,
    output logic                 W_clear,
    output logic                 md_busy,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt
);

    localparam int MDW = $clog2(MD_LATENCY + 1);
    localparam int WDW = $clog2(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t                 state_r;
    logic [MDW-1:0]         md_cnt_r;
    logic [MDW-1:0]         md_cnt_nxt_s;
    logic                   md_busy_r;
    logic [WDW-1:0]         wd_cnt_r;
    logic                   mem_timeout_r;
    logic [CNT_WIDTH-1:0]   perf_cnt_r;

    logic mem_wait_s;
    logic load_use_s;
    logic md_start_s;
    logic f_stall_s, d_stall_s, e_stall_s, m_stall_s, w_stall_s;
    logic d_clear_s, e_clear_s, m_clear_s, w_clear_s;

    // Raw hazard terms evaluated from registered state and current inputs.
    always_comb begin
        mem_wait_s = ((state_r == MEM_WAIT) & ~M_mem_ack) |
                     ((state_r == RUN) & M_mem_req & ~M_mem_ack);
        load_use_s = E_mem_read & E_w_reg_ena & (E_rd != 5'd0) &
                     ((E_rd == D_rs) | (E_rd == D_rt));
    end

    // Priority resolution: one hazard class wins per cycle; nothing asserted in reset.
    always_comb begin
        f_stall_s = 1'b0;
        d_stall_s = 1'b0;
        e_stall_s = 1'b0;
        m_stall_s = 1'b0;
        w_stall_s = 1'b0;
        d_clear_s = 1'b0;
        e_clear_s = 1'b0;
        m_clear_s = 1'b0;
        w_clear_s = 1'b0;
        if (rst) begin
            f_stall_s = 1'b0;
        end else if (mem_wait_s) begin
            // Freeze F..M; bubble into WB so the held MEM instr writes back once.
            f_stall_s = 1'b1;
            d_stall_s = 1'b1;
            e_stall_s = 1'b1;
            m_stall_s = 1'b1;
            w_clear_s = 1'b1;
        end else if (E_branch_taken) begin
            // Decode and fetch contents are wrong-path; squash them.
            d_clear_s = 1'b1;
            e_clear_s = 1'b1;
        end else if (md_busy_r & E_md_start) begin
            // Second mult/div must wait in E for the unit to drain.
            f_stall_s = 1'b1;
            d_stall_s = 1'b1;
            e_stall_s = 1'b1;
            m_clear_s = 1'b1;
        end else if (md_busy_r & D_hilo_rd) begin
            f_stall_s = 1'b1;
            d_stall_s = 1'b1;
            e_clear_s = 1'b1;
        end else if (load_use_s) begin
            f_stall_s = 1'b1;
            d_stall_s = 1'b1;
            e_clear_s = 1'b1;
        end else begin
            f_stall_s = 1'b0;
        end
    end

    // Next mult/div occupancy count: load on an accepted start, else drain.
    always_comb begin
        md_start_s   = E_md_start & ~e_stall_s & ~e_clear_s & ~md_busy_r;
        md_cnt_nxt_s = md_cnt_r;
        if (md_start_s) begin
            md_cnt_nxt_s = MDW'(MD_LATENCY);
        end else if (md_cnt_r != {MDW{1'b0}}) begin
            md_cnt_nxt_s = md_cnt_r - MDW'(1);
        end else begin
            md_cnt_nxt_s = {MDW{1'b0}};
        end
    end

    // Memory-wait FSM with watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            wd_cnt_r      <= {WDW{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    wd_cnt_r <= {WDW{1'b0}};
                    if (M_mem_req & ~M_mem_ack) begin
                        state_r <= MEM_WAIT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (wd_cnt_r != WDW'(MEM_TIMEOUT - 1)) begin
                        wd_cnt_r <= wd_cnt_r + WDW'(1);
                    end else begin
                        wd_cnt_r <= wd_cnt_r;
                    end
                    if (wd_cnt_r >= WDW'(MEM_TIMEOUT - 2)) begin
                        mem_timeout_r <= 1'b1;
                    end else begin
                        mem_timeout_r <= mem_timeout_r;
                    end
                    if (M_mem_ack) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= MEM_WAIT;
                    end
                end
                default: begin
                    state_r  <= RUN;
                    wd_cnt_r <= {WDW{1'b0}};
                end
            endcase
        end
    end

    // Mult/div occupancy counter and its registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_r  <= {MDW{1'b0}};
            md_busy_r <= 1'b0;
        end else begin
            md_cnt_r  <= md_cnt_nxt_s;
            md_busy_r <= (md_cnt_nxt_s != {MDW{1'b0}});
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (f_stall_s && (perf_cnt_r != {CNT_WIDTH{1'b1}})) begin
            perf_cnt_r <= perf_cnt_r + CNT_WIDTH'(1);
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign F_stall        = f_stall_s;
    assign D_stall        = d_stall_s;
    assign E_stall        = e_stall_s;
    assign M_stall        = m_stall_s;
    assign W_stall        = w_stall_s;
    assign D_clear        = d_clear_s;
    assign E_clear        = e_clear_s;
    assign M_clear        = m_clear_s;
    assign W_clear        = w_clear_s;
    assign md_busy        = md_busy_r;
    assign mem_timeout    = mem_timeout_r;
    assign perf_stall_cnt = perf_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MD_LATENCY=4, MEM_TIMEOUT=8.
// Each step stages inputs, pushes the expected outputs to a scoreboard queue,
// then pops and compares on the falling edge of the same cycle.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 32;

    // Control vector order: F,D,E,M,W stall then D,E,M,W clear.
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_LU   = 9'b110000100;
    localparam logic [8:0] C_BR   = 9'b000001100;
    localparam logic [8:0] C_MW   = 9'b111100001;
    localparam logic [8:0] C_MDS  = 9'b111000010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [4:0] D_rs, D_rt, E_rd;
    logic D_hilo_rd, E_w_reg_ena, E_mem_read, E_md_start, E_branch_taken, M_mem_req, M_mem_ack;
    logic F_stall, D_stall, E_stall, M_stall, W_stall;
    logic D_clear, E_clear, M_clear, W_clear;
    logic md_busy, mem_timeout;
    logic [CW-1:0] perf_stall_cnt;

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .MEM_TIMEOUT(8), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .D_rs(D_rs), .D_rt(D_rt), .D_hilo_rd(D_hilo_rd),
        .E_rd(E_rd), .E_w_reg_ena(E_w_reg_ena), .E_mem_read(E_mem_read),
        .E_md_start(E_md_start), .E_branch_taken(E_branch_taken),
        .M_mem_req(M_mem_req), .M_mem_ack(M_mem_ack),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall),
        .D_clear(D_clear), .E_clear(E_clear), .M_clear(M_clear), .W_clear(W_clear),
        .md_busy(md_busy), .mem_timeout(mem_timeout), .perf_stall_cnt(perf_stall_cnt)
    );

    typedef struct {
        logic [8:0]    ctl;
        logic          busy;
        logic          tmo;
        logic [CW-1:0] perf;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    logic [CW-1:0] perf_model;

    // Staged inputs, applied just after the next rising edge.
    logic       s_rst;
    logic [4:0] s_rs, s_rt, s_rd;
    logic       s_hilo, s_wena, s_mrd, s_mds, s_br, s_req, s_ack;

    task automatic idle_in();
        s_rs = 5'd0; s_rt = 5'd0; s_rd = 5'd0;
        s_hilo = 1'b0; s_wena = 1'b0; s_mrd = 1'b0; s_mds = 1'b0;
        s_br = 1'b0; s_req = 1'b0; s_ack = 1'b0;
    endtask

    task automatic apply_in();
        rst = s_rst; D_rs = s_rs; D_rt = s_rt; E_rd = s_rd;
        D_hilo_rd = s_hilo; E_w_reg_ena = s_wena; E_mem_read = s_mrd;
        E_md_start = s_mds; E_branch_taken = s_br; M_mem_req = s_req; M_mem_ack = s_ack;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic go(input logic [8:0] ctl, input logic busy, input logic tmo, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        apply_in();
        e.ctl  = ctl;
        e.busy = busy;
        e.tmo  = tmo;
        e.perf = perf_model;
        sb_q.push_back(e);
        if (s_rst) perf_model = '0;
        else if (ctl[8] && (perf_model != {CW{1'b1}})) perf_model = perf_model + 1;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "/ctl"}, {23'd0, F_stall, D_stall, E_stall, M_stall, W_stall,
                                  D_clear, E_clear, M_clear, W_clear}, {23'd0, e.ctl});
            check({tag, "/md_busy"}, {31'd0, md_busy}, {31'd0, e.busy});
            check({tag, "/timeout"}, {31'd0, mem_timeout}, {31'd0, e.tmo});
            check({tag, "/perf"}, perf_stall_cnt, e.perf);
        end
    endtask

    initial begin
        idle_in();
        s_rst = 1'b1;
        apply_in();
        perf_model = '0;
        repeat (2) @(posedge clk);
        go(C_NONE, 1'b0, 1'b0, "reset");
        s_rst = 1'b0;

        // T1 load-use via rs, then via rt, and non-hazard variants
        idle_in(); s_mrd = 1'b1; s_wena = 1'b1; s_rd = 5'd5; s_rs = 5'd5;
        go(C_LU, 1'b0, 1'b0, "lu_rs");
        idle_in(); go(C_NONE, 1'b0, 1'b0, "after_lu");
        idle_in(); s_mrd = 1'b1; s_wena = 1'b1; s_rd = 5'd7; s_rs = 5'd3; s_rt = 5'd7;
        go(C_LU, 1'b0, 1'b0, "lu_rt");
        idle_in(); s_mrd = 1'b1; s_wena = 1'b1; s_rd = 5'd7; s_rs = 5'd3; s_rt = 5'd4;
        go(C_NONE, 1'b0, 1'b0, "lu_nomatch");
        idle_in(); s_mrd = 1'b1; s_wena = 1'b0; s_rd = 5'd9; s_rs = 5'd9;
        go(C_NONE, 1'b0, 1'b0, "lu_nowrite");

        // T2 zero register never hazards; redirect beats load-use
        idle_in(); s_mrd = 1'b1; s_wena = 1'b1; s_rd = 5'd0; s_rs = 5'd0;
        go(C_NONE, 1'b0, 1'b0, "lu_r0");
        idle_in(); s_mrd = 1'b1; s_wena = 1'b1; s_rd = 5'd5; s_rs = 5'd5; s_br = 1'b1;
        go(C_BR, 1'b0, 1'b0, "br_over_lu");

        // T3 three wait cycles, release on ack, single-cycle ack, redirect under wait
        idle_in(); s_req = 1'b1;
        go(C_MW, 1'b0, 1'b0, "mw1");
        go(C_MW, 1'b0, 1'b0, "mw2");
        go(C_MW, 1'b0, 1'b0, "mw3");
        s_ack = 1'b1; go(C_NONE, 1'b0, 1'b0, "mw_ack");
        go(C_NONE, 1'b0, 1'b0, "ack_same_cycle");
        idle_in(); go(C_NONE, 1'b0, 1'b0, "idle_run");
        idle_in(); s_req = 1'b1; s_br = 1'b1;
        go(C_MW, 1'b0, 1'b0, "br_in_wait");
        s_ack = 1'b1; go(C_BR, 1'b0, 1'b0, "br_on_release");

        // T4 mult/div occupancy blocks a HI/LO reader for MD_LATENCY cycles
        idle_in(); s_mds = 1'b1; go(C_NONE, 1'b0, 1'b0, "md_start");
        idle_in(); s_hilo = 1'b1;
        for (int i = 0; i < 4; i++) go(C_LU, 1'b1, 1'b0, "hilo_wait");
        go(C_NONE, 1'b0, 1'b0, "hilo_release");
        // second start while busy, and redirect overriding the md conflict
        idle_in(); s_mds = 1'b1; go(C_NONE, 1'b0, 1'b0, "md_start2");
        go(C_MDS, 1'b1, 1'b0, "md_second_op");
        idle_in(); s_hilo = 1'b1; s_br = 1'b1; go(C_BR, 1'b1, 1'b0, "br_over_md");
        idle_in(); go(C_NONE, 1'b1, 1'b0, "md_drain2");
        go(C_NONE, 1'b1, 1'b0, "md_drain1");
        go(C_NONE, 1'b0, 1'b0, "md_done");

        // T5 watchdog after eight wait cycles, sticky across ack
        idle_in(); s_req = 1'b1;
        for (int i = 0; i < 8; i++) go(C_MW, 1'b0, 1'b0, "wd_wait");
        go(C_MW, 1'b0, 1'b1, "wd_fired");
        s_ack = 1'b1; go(C_NONE, 1'b0, 1'b1, "wd_ack");
        idle_in(); go(C_NONE, 1'b0, 1'b1, "wd_sticky");

        // T6 reset during memory wait with mult/div busy
        idle_in(); s_mds = 1'b1; go(C_NONE, 1'b0, 1'b1, "t6_md_start");
        idle_in(); s_req = 1'b1; go(C_MW, 1'b1, 1'b1, "t6_wait1");
        go(C_MW, 1'b1, 1'b1, "t6_wait2");
        s_rst = 1'b1; go(C_NONE, 1'b1, 1'b1, "t6_in_rst");
        s_rst = 1'b0; idle_in(); go(C_NONE, 1'b0, 1'b0, "t6_after_rst");
        go(C_NONE, 1'b0, 1'b0, "t6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
